nin_router: RTL and testbench
=============================

Name: nin_router

Overview:
- Parametrised N-input, single-output, two-class flit router; successor to the fixed 3-input/16-bit router.
- Flits are classified by their 3-bit head field into a priority FIFO or a regular FIFO.
- Each class has its own round-robin write arbiter. A registered output stage drains the FIFOs: strict priority, with a programmable anti-starvation limit for regular traffic.
- Sits between up to NUM_IN upstream ports and one downstream link using the existing req/bussy handshake.

Parameters:
- NUM_IN, 3, number of input ports (2..8).
- DATA_W, 16, flit width; head field is data[DATA_W-1:DATA_W-3].
- FIFO_DEPTH, 4, entries per class FIFO; power of two, at least 2.
- PRIO_HEAD, 3'b001, head value routed to the priority FIFO; every other head value goes to the regular FIFO.
- STARVE_MAX, 4, consecutive priority pops allowed while regular is waiting; 0 = strict priority, never forced.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- input_data  in  NUM_IN*DATA_W  port i occupies bits [i*DATA_W +: DATA_W].
- input_req  in  NUM_IN  port i presents a valid flit.
- input_bussy  out  NUM_IN  1 = flit on port i not accepted this cycle.
- output_data  out  DATA_W  registered output flit.
- output_req  out  1  output_data valid.
- output_bussy  in  1  downstream cannot accept.
- prio_level  out  $clog2(FIFO_DEPTH+1)  priority FIFO occupancy.
- reg_level  out  $clog2(FIFO_DEPTH+1)  regular FIFO occupancy.

Behaviour:
- Reset, reset low, asynchronous:
  - FIFO pointers and levels = 0.
  - Both round-robin pointers = 0.
  - starve_cnt = 0.
  - output_req = 0, output_data = 0.
  - input_bussy = all 1s while reset is low.
- Reset mid-operation discards all buffered flits and the output slot.
- Input side, per class c:
  - Candidates are inputs with input_req=1 and a head field matching c.
  - If FIFO c is full, there is no grant for c. Full blocks writes even when a pop occurs in the same cycle.
  - Otherwise grant the first candidate at or after rr_ptr[c], searching upward with wrap.
  - input_bussy[i] = 0 only when port i is granted in its class; this is combinational in the same cycle.
  - Flit is written at the rising edge where input_req[i]=1 and input_bussy[i]=0.
  - After a grant to port g, rr_ptr[c] <= (g+1) mod NUM_IN. No grant leaves the pointer unchanged.
  - One priority and one regular flit may be accepted in the same cycle from different ports.
  - A port with input_req=0 has input_bussy=1; upstream ignores it.
- FIFOs:
  - Circular buffers with separate read and write pointers that wrap at FIFO_DEPTH.
  - Simultaneous write and read keeps the level unchanged.
  - Write when full or read when empty never occurs, because both are gated.
- Output stage:
  - Slot is free when output_req=0, or when output_req=1 and output_bussy=0 (accepted this edge).
  - If the slot is free, load at the edge:
    - Regular, if regular is non-empty and (priority empty, or STARVE_MAX>0 and starve_cnt==STARVE_MAX).
    - Else priority, if priority is non-empty.
    - Else output_req <= 0.
  - output_data holds its value when not loading.
- starve_cnt:
  - Increments on a priority load while regular is non-empty.
  - Clears on a regular load, or whenever regular is empty.
  - Saturates at STARVE_MAX.
- Latency: flit accepted at edge k, both FIFOs otherwise empty, output slot free → output_req=1 with that flit after edge k+1.
- Throughput: one flit per cycle while output_bussy=0.
- Ordering: FIFO order within a class; no cross-class ordering guarantee.
- output_bussy high holds output_req and output_data stable until accepted.

Test Plan:
- Single regular flit 16'h0ABC on port 0, idle → input_bussy[0]=0 that cycle; output_req=1, output_data=16'h0ABC two edges later; reg_level returns to 0.
- Ports 0,1,2 each hold regular flits continuously, output_bussy=0 → grants rotate 0,1,2,0,…; each port receives exactly one grant per 3 cycles.
- Fill regular FIFO with 4 flits, output_bussy=1 → reg_level=4; further regular input_bussy=1. A simultaneous priority flit (head 001) is still accepted; prio_level=1.
- Priority and regular both backlogged, STARVE_MAX=4 → output class sequence P,P,P,P,R,P,P,P,P,R; with STARVE_MAX=0, all P before any R.
- output_bussy toggled randomly over 200 flits → no loss, no duplication, output_data stable while bussy; per-class order matches scoreboard.
- Assert reset low mid-transfer with 3 flits buffered → immediately output_req=0, levels=0. After release, the first new flit appears with 1-edge FIFO latency.

Source files
------------

// File: rtl/nin_router.sv
// ----------------------------------------------------------------------------
// nin_router
//
// Parametrised N-input, single-output, two-class flit router. Incoming flits
// are classified by their 3-bit head field: a head equal to PRIO_HEAD goes to
// the priority FIFO, every other head goes to the regular FIFO. Each class has
// its own round-robin write arbiter, so one priority and one regular flit can
// be accepted in the same cycle from different ports. A registered output
// stage drains the FIFOs with strict priority, except that after STARVE_MAX
// consecutive priority loads while regular traffic waits, one regular flit is
// forced through (STARVE_MAX = 0 disables this and gives pure strict priority).
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   input_data    NUM_IN flits, port i at [i*DATA_W +: DATA_W]
//   input_req     per-port flit valid
//   input_bussy   per-port "not accepted this cycle" (combinational)
//   output_data   registered output flit
//   output_req    output_data valid
//   output_bussy  downstream cannot accept
//   prio_level    priority FIFO occupancy
//   reg_level     regular FIFO occupancy
// ----------------------------------------------------------------------------
module nin_router #(
    parameter int         NUM_IN     = 3,
    parameter int         DATA_W     = 16,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] PRIO_HEAD  = 3'b001,
    parameter int         STARVE_MAX = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_IN*DATA_W-1:0]            input_data,
    input  logic [NUM_IN-1:0]                   input_req,
    output logic [NUM_IN-1:0]                   input_bussy,
    output logic [DATA_W-1:0]                   output_data,
    output logic                                output_req,
    input  logic                                output_bussy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     prio_level,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     reg_level
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX+1) : 1;

    localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic              STARVE_EN  = (STARVE_MAX > 0);
    localparam logic [IDX_W-1:0]  LAST_PORT  = IDX_W'(NUM_IN-1);
    localparam logic [NUM_IN-1:0] ONE_HOT    = NUM_IN'(1);

    // ------------------------------------------------------------------------
    // Round-robin search: first set bit of cand at or after ptr, wrapping.
    // Returns {found, index}.
    // ------------------------------------------------------------------------
    function automatic logic [IDX_W:0] rrPick(input logic [NUM_IN-1:0] cand,
                                              input logic [IDX_W-1:0]  ptr);
        logic              found;
        logic [IDX_W-1:0]  sel;
        logic [NUM_IN-1:0] shifted;
        int                idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            shifted = cand >> idx;
            if (!found && shifted[0]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
        return {found, sel};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_prioMem [FIFO_DEPTH];
    logic [DATA_W-1:0] r_regMem  [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_prioWr, r_prioRd, r_regWr, r_regRd;
    logic [LVL_W-1:0]  r_prioLvl, r_regLvl;
    logic [IDX_W-1:0]  r_prioRr, r_regRr;
    logic [CNT_W-1:0]  r_starveCnt;
    logic [DATA_W-1:0] r_outData;
    logic              r_outReq;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [NUM_IN-1:0] w_prioCand, w_regCand;
    logic [IDX_W:0]    w_prioPick, w_regPick;
    logic [IDX_W-1:0]  w_prioIdx, w_regIdx;
    logic              w_prioFull, w_regFull, w_prioEmpty, w_regEmpty;
    logic              w_prioWrEn, w_regWrEn;
    logic [NUM_IN-1:0] w_prioGrant, w_regGrant;
    logic [DATA_W-1:0] w_prioWrData, w_regWrData;
    logic              w_slotFree, w_regSel, w_prioSel;

    // Split requesting ports into the two classes by head field.
    always_comb begin
        w_prioCand = '0;
        w_regCand  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (input_req[i]) begin
                if (input_data[i*DATA_W + DATA_W - 3 +: 3] == PRIO_HEAD) begin
                    w_prioCand[i] = 1'b1;
                end else begin
                    w_regCand[i] = 1'b1;
                end
            end
        end
    end

    assign w_prioFull  = (r_prioLvl == LVL_FULL);
    assign w_regFull   = (r_regLvl  == LVL_FULL);
    assign w_prioEmpty = (r_prioLvl == '0);
    assign w_regEmpty  = (r_regLvl  == '0);

    assign w_prioPick = rrPick(w_prioCand, r_prioRr);
    assign w_regPick  = rrPick(w_regCand,  r_regRr);
    assign w_prioIdx  = w_prioPick[IDX_W-1:0];
    assign w_regIdx   = w_regPick[IDX_W-1:0];

    // A full FIFO refuses writes even if it is popped in the same cycle;
    // this keeps the full flag purely registered and off the output path.
    assign w_prioWrEn = w_prioPick[IDX_W] && !w_prioFull;
    assign w_regWrEn  = w_regPick[IDX_W]  && !w_regFull;

    assign w_prioGrant = w_prioWrEn ? (ONE_HOT << w_prioIdx) : '0;
    assign w_regGrant  = w_regWrEn  ? (ONE_HOT << w_regIdx)  : '0;

    // Held all-busy while reset is asserted, independent of the clock.
    assign input_bussy = reset ? ~(w_prioGrant | w_regGrant) : '1;

    // Select the granted port's flit for each class.
    always_comb begin
        w_prioWrData = '0;
        w_regWrData  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_prioGrant[i]) begin
                w_prioWrData = input_data[i*DATA_W +: DATA_W];
            end
            if (w_regGrant[i]) begin
                w_regWrData = input_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output slot is free when empty or being taken by downstream this edge.
    // Regular wins only when priority is empty or the starvation limit hit.
    assign w_slotFree = !r_outReq || !output_bussy;
    assign w_regSel   = w_slotFree && !w_regEmpty &&
                        (w_prioEmpty || (STARVE_EN && (r_starveCnt == STARVE_LIM)));
    assign w_prioSel  = w_slotFree && !w_regSel && !w_prioEmpty;

    // ------------------------------------------------------------------------
    // FIFO storage (no reset needed; validity is tracked by the pointers)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_prioWrEn) begin
            r_prioMem[r_prioWr] <= w_prioWrData;
        end
        if (w_regWrEn) begin
            r_regMem[r_regWr] <= w_regWrData;
        end
    end

    // ------------------------------------------------------------------------
    // Priority FIFO pointers, level and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prioWr  <= '0;
            r_prioRd  <= '0;
            r_prioLvl <= '0;
            r_prioRr  <= '0;
        end else begin
            if (w_prioWrEn) begin
                r_prioWr <= r_prioWr + PTR_W'(1);
                r_prioRr <= (w_prioIdx == LAST_PORT) ? '0 : w_prioIdx + IDX_W'(1);
            end
            if (w_prioSel) begin
                r_prioRd <= r_prioRd + PTR_W'(1);
            end
            if (w_prioWrEn && !w_prioSel) begin
                r_prioLvl <= r_prioLvl + LVL_W'(1);
            end else if (!w_prioWrEn && w_prioSel) begin
                r_prioLvl <= r_prioLvl - LVL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Regular FIFO pointers, level and round-robin pointer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regWr  <= '0;
            r_regRd  <= '0;
            r_regLvl <= '0;
            r_regRr  <= '0;
        end else begin
            if (w_regWrEn) begin
                r_regWr <= r_regWr + PTR_W'(1);
                r_regRr <= (w_regIdx == LAST_PORT) ? '0 : w_regIdx + IDX_W'(1);
            end
            if (w_regSel) begin
                r_regRd <= r_regRd + PTR_W'(1);
            end
            if (w_regWrEn && !w_regSel) begin
                r_regLvl <= r_regLvl + LVL_W'(1);
            end else if (!w_regWrEn && w_regSel) begin
                r_regLvl <= r_regLvl - LVL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register and starvation counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outReq    <= 1'b0;
            r_outData   <= '0;
            r_starveCnt <= '0;
        end else begin
            if (w_slotFree) begin
                if (w_regSel) begin
                    r_outReq  <= 1'b1;
                    r_outData <= r_regMem[r_regRd];
                end else if (w_prioSel) begin
                    r_outReq  <= 1'b1;
                    r_outData <= r_prioMem[r_prioRd];
                end else begin
                    r_outReq  <= 1'b0;
                end
            end
            // Counts priority loads only while regular traffic is waiting;
            // stops at the limit rather than wrapping.
            if (w_regEmpty || w_regSel) begin
                r_starveCnt <= '0;
            end else if (w_prioSel && (r_starveCnt != STARVE_LIM)) begin
                r_starveCnt <= r_starveCnt + CNT_W'(1);
            end
        end
    end

    assign output_req  = r_outReq;
    assign output_data = r_outData;
    assign prio_level  = r_prioLvl;
    assign reg_level   = r_regLvl;

endmodule

// File: tb/tb_nin_router.sv
// ----------------------------------------------------------------------------
// tb_nin_router
//
// Directed bench for nin_router with default parameters (u_dut) plus a second
// copy with STARVE_MAX = 0 (u_strict) sharing the same inputs, used to compare
// bounded-starvation and strict-priority draining.
// ----------------------------------------------------------------------------
module tb_nin_router;

    localparam int NUM_IN     = 3;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH+1);

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_IN*DATA_W-1:0]   inputData;
    logic [NUM_IN-1:0]          inputReq;
    logic [NUM_IN-1:0]          inputBussy, inputBussyS;
    logic [DATA_W-1:0]          outputData, outputDataS;
    logic                       outputReq, outputReqS;
    logic                       outputBussy;
    logic [LVL_W-1:0]           prioLevel, regLevel, prioLevelS, regLevelS;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    nin_router #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                 .PRIO_HEAD(3'b001), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .input_data(inputData), .input_req(inputReq), .input_bussy(inputBussy),
        .output_data(outputData), .output_req(outputReq), .output_bussy(outputBussy),
        .prio_level(prioLevel), .reg_level(regLevel)
    );

    nin_router #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                 .PRIO_HEAD(3'b001), .STARVE_MAX(0)) u_strict (
        .clk(clk), .reset(reset),
        .input_data(inputData), .input_req(inputReq), .input_bussy(inputBussyS),
        .output_data(outputDataS), .output_req(outputReqS), .output_bussy(outputBussy),
        .prio_level(prioLevelS), .reg_level(regLevelS)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one upstream port.
    task automatic applyStimulus(input int p, input logic req, input logic [15:0] data);
        inputReq[p]             = req;
        inputData[p*16 +: 16]   = data;
    endtask

    // Holds reset for two cycles and releases it on a falling clock edge.
    task automatic doReset();
        reset       = 1'b0;
        inputReq    = '0;
        inputData   = '0;
        outputBussy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Bounded overall run time.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [2:0]  expBussy;
    logic [15:0] flit;
    logic [15:0] prevData;
    logic        prevHeld;
    logic        found;
    logic [2:0]  head;
    logic [12:0] tag;
    logic [15:0] expP[$];
    logic [15:0] expR[$];
    int          accepted;
    int          sent;
    int          received;

    initial begin
        // ---------------- reset values ----------------
        reset       = 1'b0;
        outputBussy = 1'b0;
        inputData   = {16'h0003, 16'h2002, 16'h0001};
        inputReq    = 3'b111;
        #1;
        checkOutput("rst_bussy",      32'(inputBussy), 32'h7);
        checkOutput("rst_out_req",    32'(outputReq),  32'h0);
        checkOutput("rst_out_data",   32'(outputData), 32'h0);
        checkOutput("rst_prio_level", 32'(prioLevel),  32'h0);
        checkOutput("rst_reg_level",  32'(regLevel),   32'h0);

        // ---------------- single regular flit ----------------
        doReset();
        applyStimulus(0, 1'b1, 16'h0ABC);
        #1;
        checkOutput("single_bussy", 32'(inputBussy), 32'h6);
        @(negedge clk);
        inputReq = '0;
        checkOutput("single_reg_level1", 32'(regLevel),  32'h1);
        checkOutput("single_req_early",  32'(outputReq), 32'h0);
        @(negedge clk);
        checkOutput("single_req",        32'(outputReq),  32'h1);
        checkOutput("single_data",       32'(outputData), 32'h0ABC);
        checkOutput("single_reg_level0", 32'(regLevel),   32'h0);
        @(negedge clk);
        checkOutput("single_req_drop",   32'(outputReq),  32'h0);

        // ---------------- round-robin rotation ----------------
        doReset();
        applyStimulus(0, 1'b1, 16'h0100);
        applyStimulus(1, 1'b1, 16'h0101);
        applyStimulus(2, 1'b1, 16'h0102);
        for (int j = 0; j < 6; j++) begin
            #1;
            expBussy = 3'b111 ^ (3'b001 << (j % 3));
            checkOutput("rr_grant", 32'(inputBussy), 32'(expBussy));
            @(negedge clk);
        end
        inputReq = '0;
        checkOutput("rr_out_a", 32'(outputData), 32'h0101);
        @(negedge clk);
        checkOutput("rr_out_b", 32'(outputData), 32'h0102);

        // ---------------- fill regular FIFO, priority still accepted ----------------
        doReset();
        outputBussy = 1'b1;
        accepted    = 0;
        for (int j = 0; j < 8; j++) begin
            applyStimulus(0, 1'b1, 16'h0200 + 16'(accepted));
            #1;
            checkOutput("fill_bussy0", 32'(inputBussy[0]), (j >= 5) ? 32'h1 : 32'h0);
            if (!inputBussy[0]) accepted++;
            @(negedge clk);
        end
        checkOutput("fill_reg_level", 32'(regLevel),   32'h4);
        checkOutput("fill_out_held",  32'(outputData), 32'h0200);
        applyStimulus(1, 1'b1, 16'h2555);
        #1;
        checkOutput("fill_prio_grant", 32'(inputBussy), 32'h5);
        @(negedge clk);
        inputReq = '0;
        checkOutput("fill_prio_level",  32'(prioLevel),  32'h1);
        checkOutput("fill_reg_level2",  32'(regLevel),   32'h4);
        checkOutput("fill_out_req",     32'(outputReq),  32'h1);
        checkOutput("fill_out_held2",   32'(outputData), 32'h0200);
        outputBussy = 1'b0;
        @(negedge clk);
        checkOutput("drain_prio", 32'(outputData), 32'h2555);
        for (int j = 1; j < 5; j++) begin
            @(negedge clk);
            checkOutput("drain_reg", 32'(outputData), 32'h0200 + 32'(j));
        end
        @(negedge clk);
        checkOutput("drain_idle", 32'(outputReq), 32'h0);

        // ---------------- starvation limit vs strict priority ----------------
        doReset();
        outputBussy = 1'b1;
        applyStimulus(0, 1'b1, 16'h2001);
        applyStimulus(1, 1'b1, 16'h0002);
        repeat (6) @(negedge clk);
        outputBussy = 1'b0;
        for (int j = 0; j < 10; j++) begin
            checkOutput("starve_seq_is_reg", 32'(outputData[15:13] != 3'b001),
                        (j % 5 == 4) ? 32'h1 : 32'h0);
            checkOutput("strict_all_prio", 32'(outputDataS[15:13]), 32'h1);
            @(negedge clk);
        end
        applyStimulus(0, 1'b0, 16'h0000);
        found = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (outputReqS && outputDataS[15:13] != 3'b001) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("strict_reg_after_prio", 32'(found), 32'h1);

        // ---------------- random output backpressure, scoreboard ----------------
        doReset();
        sent     = 0;
        received = 0;
        prevHeld = 1'b0;
        prevData = '0;
        tag      = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (sent >= 200 && expP.size() == 0 && expR.size() == 0) break;
            if (prevHeld) begin
                checkOutput("hold_req",  32'(outputReq),  32'h1);
                checkOutput("hold_data", 32'(outputData), 32'(prevData));
            end
            outputBussy = ($urandom_range(0, 9) < 4);
            if (outputReq && !outputBussy) begin
                received++;
                if (outputData[15:13] == 3'b001) begin
                    if (expP.size() == 0) checkOutput("rand_prio_expected", 32'(expP.size()), 32'h1);
                    else checkOutput("rand_prio_order", 32'(outputData), 32'(expP.pop_front()));
                end else begin
                    if (expR.size() == 0) checkOutput("rand_reg_expected", 32'(expR.size()), 32'h1);
                    else checkOutput("rand_reg_order", 32'(outputData), 32'(expR.pop_front()));
                end
            end
            prevHeld = outputReq && outputBussy;
            prevData = outputData;
            for (int p = 0; p < NUM_IN; p++) begin
                if (sent < 200 && $urandom_range(0, 2) != 0) begin
                    head = $urandom_range(0, 1) ? 3'b001 : 3'($urandom_range(0, 7));
                    applyStimulus(p, 1'b1, {head, tag});
                    tag++;
                end else begin
                    applyStimulus(p, 1'b0, 16'h0000);
                end
            end
            #1;
            for (int p = 0; p < NUM_IN; p++) begin
                if (inputReq[p] && !inputBussy[p]) begin
                    flit = inputData[p*16 +: 16];
                    if (flit[15:13] == 3'b001) expP.push_back(flit);
                    else expR.push_back(flit);
                    sent++;
                end
            end
            @(negedge clk);
        end
        inputReq    = '0;
        outputBussy = 1'b0;
        checkOutput("rand_count", 32'(received), 32'(sent));
        checkOutput("rand_queues_empty", 32'(expP.size() + expR.size()), 32'h0);

        // ---------------- reset mid-transfer ----------------
        doReset();
        outputBussy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            applyStimulus(2, 1'b1, 16'h0300 + 16'(j));
            @(negedge clk);
        end
        inputReq = '0;
        checkOutput("mid_reg_level", 32'(regLevel),  32'h3);
        checkOutput("mid_out_req",   32'(outputReq), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_req",        32'(outputReq),  32'h0);
        checkOutput("mid_rst_data",       32'(outputData), 32'h0);
        checkOutput("mid_rst_reg_level",  32'(regLevel),   32'h0);
        checkOutput("mid_rst_prio_level", 32'(prioLevel),  32'h0);
        checkOutput("mid_rst_bussy",      32'(inputBussy), 32'h7);
        @(negedge clk);
        reset       = 1'b1;
        outputBussy = 1'b0;
        applyStimulus(1, 1'b1, 16'h0777);
        #1;
        checkOutput("post_rst_grant", 32'(inputBussy), 32'h5);
        @(negedge clk);
        inputReq = '0;
        checkOutput("post_rst_req_early", 32'(outputReq), 32'h0);
        @(negedge clk);
        checkOutput("post_rst_req",  32'(outputReq),  32'h1);
        checkOutput("post_rst_data", 32'(outputData), 32'h0777);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
